gpio_mailbox_ctrl: RTL and testbench

//  Byte-mailbox controller between the USB register file and the PULPino GPIO port, on the

---
 rtl/gpio_mailbox_ctrl_pkg.sv | 17 +
 rtl/gpio_mailbox_ctrl_fifo.sv | 64 ++++++
 rtl/gpio_mailbox_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gpio_mailbox_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_mailbox_ctrl_pkg.sv
// Shared definitions for the GPIO byte mailbox: flag bit positions on the
// flicker handshake lines and the TX handshake state encoding.
package gpio_mailbox_ctrl_pkg;

  // Bit positions inside ext_flags / pulpino_flags
  localparam int READ_FLICKER  = 0;
  localparam int WRITE_FLICKER = 1;

  // TX handshake FSM: one byte takes IDLE -> LOAD -> SIGNAL -> WAIT_ACK
  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_LOAD     = 2'd1,
    TX_SIGNAL   = 2'd2,
    TX_WAIT_ACK = 2'd3
  } tx_state_e;

endpackage

// File: rtl/gpio_mailbox_ctrl_fifo.sv
// Byte-wide synchronous FIFO with occupancy output. Pointers carry one extra
// bit so that full and empty are distinguishable; the read data is forced to
// zero while empty so the head never exposes stale storage.
module mailbox_fifo #(
  parameter int pDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(pDEPTH):0]  level_o
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;

  logic [7:0]  mem_q [pDEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok;
  logic        pop_ok;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == LW'(pDEPTH));
  assign empty_o = (level_o == '0);
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;
  assign data_o  = empty_o ? 8'h00 : mem_q[rptr_q[AW-1:0]];

  // Pointer next-state: flush wins, otherwise advance on accepted push/pop
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset because the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/gpio_mailbox_ctrl.sv
// Byte mailbox between the USB register file and the PULPino GPIO port.
// Host->core bytes queue in a TX FIFO and are handed over with the write
// flicker handshake; core->host bytes arrive on the read flicker handshake
// and queue in an RX FIFO. A flag edge of either polarity is one event.
module gpio_mailbox_ctrl
  import gpio_mailbox_ctrl_pkg::*;
#(
  parameter int pFIFO_DEPTH = 8,
  parameter int pTIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          I_clear,
  input  logic [7:0]                    I_tx_data,
  input  logic                          I_tx_valid,
  output logic                          O_tx_ready,
  output logic [7:0]                    O_rx_data,
  output logic                          O_rx_valid,
  input  logic                          I_rx_ready,
  output logic [7:0]                    O_ext_data,
  output logic [7:0]                    O_ext_flags,
  input  logic [7:0]                    I_pulpino_data,
  input  logic [7:0]                    I_pulpino_flags,
  output logic [$clog2(pFIFO_DEPTH):0]  O_tx_level,
  output logic [$clog2(pFIFO_DEPTH):0]  O_rx_level,
  output logic                          O_busy,
  output logic                          O_timeout
);

  localparam int CNT_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((pTIMEOUT > 0) ? pTIMEOUT - 1 : 0);

  tx_state_e        state_q, state_d;
  logic [7:0]       ext_data_q, ext_data_d;
  logic             wr_flick_q, wr_flick_d;
  logic             rd_flick_q, rd_flick_d;
  logic             tx_ack_seen_q, tx_ack_seen_d;
  logic             rx_req_seen_q, rx_req_seen_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic             ack_flag, req_flag;
  logic             unused_flags;

  assign ack_flag     = I_pulpino_flags[READ_FLICKER];
  assign req_flag     = I_pulpino_flags[WRITE_FLICKER];
  assign unused_flags = ^I_pulpino_flags[7:2];

  assign tx_push = I_tx_valid && !tx_full;
  assign rx_pop  = I_rx_ready && !rx_empty;
  // A core write is taken only when there is room; otherwise it stays pending
  assign rx_push = (req_flag != rx_req_seen_q) && !rx_full && !I_clear;

  mailbox_fifo #(.pDEPTH(pFIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (I_clear),
    .push_i  (tx_push),
    .data_i  (I_tx_data),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (O_tx_level)
  );

  mailbox_fifo #(.pDEPTH(pFIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (I_clear),
    .push_i  (rx_push),
    .data_i  (I_pulpino_data),
    .pop_i   (rx_pop),
    .data_o  (O_rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (O_rx_level)
  );

  // TX handshake FSM and RX acknowledge: next state, flag toggles, timeout
  always_comb begin
    state_d       = state_q;
    ext_data_d    = ext_data_q;
    wr_flick_d    = wr_flick_q;
    rd_flick_d    = rd_flick_q;
    tx_ack_seen_d = tx_ack_seen_q;
    rx_req_seen_d = rx_req_seen_q;
    timeout_d     = timeout_q;
    cnt_d         = cnt_q;
    tx_pop        = 1'b0;
    if (I_clear) begin
      // Resync the seen registers so any edge pending now is dropped
      state_d       = TX_IDLE;
      cnt_d         = '0;
      timeout_d     = 1'b0;
      tx_ack_seen_d = ack_flag;
      rx_req_seen_d = req_flag;
    end else begin
      unique case (state_q)
        TX_IDLE: begin
          if (!tx_empty) state_d = TX_LOAD;
        end
        TX_LOAD: begin
          // Data goes out one cycle ahead of the flag toggle
          ext_data_d = tx_head;
          tx_pop     = 1'b1;
          state_d    = TX_SIGNAL;
        end
        TX_SIGNAL: begin
          wr_flick_d = ~wr_flick_q;
          cnt_d      = '0;
          state_d    = TX_WAIT_ACK;
        end
        TX_WAIT_ACK: begin
          if (ack_flag != tx_ack_seen_q) begin
            tx_ack_seen_d = ack_flag;
            state_d       = TX_IDLE;
          end else if (pTIMEOUT != 0) begin
            // Counter parks at its last value; the flag is sticky
            if (cnt_q == CNT_LAST) timeout_d = 1'b1;
            else                   cnt_d     = cnt_q + 1'b1;
          end
        end
        default: state_d = TX_IDLE;
      endcase
      if (rx_push) begin
        rx_req_seen_d = req_flag;
        rd_flick_d    = ~rd_flick_q;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TX_IDLE;
      ext_data_q    <= 8'h00;
      wr_flick_q    <= 1'b0;
      rd_flick_q    <= 1'b0;
      tx_ack_seen_q <= 1'b0;
      rx_req_seen_q <= 1'b0;
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ext_data_q    <= ext_data_d;
      wr_flick_q    <= wr_flick_d;
      rd_flick_q    <= rd_flick_d;
      tx_ack_seen_q <= tx_ack_seen_d;
      rx_req_seen_q <= rx_req_seen_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Flag byte toward the core: only the two flicker bits are used
  always_comb begin
    O_ext_flags                = 8'h00;
    O_ext_flags[READ_FLICKER]  = rd_flick_q;
    O_ext_flags[WRITE_FLICKER] = wr_flick_q;
  end

  assign O_ext_data = ext_data_q;
  assign O_tx_ready = !tx_full;
  assign O_rx_valid = !rx_empty;
  assign O_busy     = (state_q != TX_IDLE) || !tx_empty;
  assign O_timeout  = timeout_q;

endmodule

// File: tb/tb_gpio_mailbox_ctrl.sv
// Bench for gpio_mailbox_ctrl: the bench plays both the host and the PULPino
// core. Directed steps cover reset, the handshake sequences, stall, timeout
// and flush; a random phase is scored against byte-order queues.
module tb_gpio_mailbox_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          I_clear;
  logic [7:0]    I_tx_data;
  logic          I_tx_valid;
  logic          O_tx_ready;
  logic [7:0]    O_rx_data;
  logic          O_rx_valid;
  logic          I_rx_ready;
  logic [7:0]    O_ext_data;
  logic [7:0]    O_ext_flags;
  logic [7:0]    I_pulpino_data;
  logic [7:0]    I_pulpino_flags;
  logic [LW-1:0] O_tx_level;
  logic [LW-1:0] O_rx_level;
  logic          O_busy;
  logic          O_timeout;

  gpio_mailbox_ctrl #(.pFIFO_DEPTH(DEPTH), .pTIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .I_clear         (I_clear),
    .I_tx_data       (I_tx_data),
    .I_tx_valid      (I_tx_valid),
    .O_tx_ready      (O_tx_ready),
    .O_rx_data       (O_rx_data),
    .O_rx_valid      (O_rx_valid),
    .I_rx_ready      (I_rx_ready),
    .O_ext_data      (O_ext_data),
    .O_ext_flags     (O_ext_flags),
    .I_pulpino_data  (I_pulpino_data),
    .I_pulpino_flags (I_pulpino_flags),
    .O_tx_level      (O_tx_level),
    .O_rx_level      (O_rx_level),
    .O_busy          (O_busy),
    .O_timeout       (O_timeout)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       wr_seen, rd_seen;
  logic       ok, acked, must_ack, req_pend, filling;
  int         ack_dly;
  logic [7:0] req_data, saved_flags;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Core side: wait (bounded) for the write flicker to change
  task automatic wait_wr(output logic ok_o);
    for (int i = 0; i < 20; i++) begin
      if (O_ext_flags[1] !== wr_seen) break;
      tick();
    end
    ok_o    = (O_ext_flags[1] !== wr_seen);
    wr_seen = O_ext_flags[1];
  endtask

  initial begin
    I_clear = 1'b0; I_tx_data = 8'h00; I_tx_valid = 1'b0; I_rx_ready = 1'b0;
    I_pulpino_data = 8'h00; I_pulpino_flags = 8'h00;
    wr_seen = 1'b0; rd_seen = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_ready", O_tx_ready, 1);
    check("rst_rx_valid", O_rx_valid, 0);
    check("rst_rx_data", O_rx_data, 0);
    check("rst_ext_data", O_ext_data, 0);
    check("rst_ext_flags", O_ext_flags, 0);
    check("rst_tx_level", O_tx_level, 0);
    check("rst_rx_level", O_rx_level, 0);
    check("rst_busy", O_busy, 0);
    check("rst_timeout", O_timeout, 0);
    rst_n = 1'b1;
    tick();

    // single byte 0xA5 through the write handshake
    I_tx_data = 8'hA5; I_tx_valid = 1'b1;
    tick();
    I_tx_valid = 1'b0;
    check("t1_level", O_tx_level, 1);
    check("t1_busy", O_busy, 1);
    tick();
    check("t1_load_hold", O_ext_data, 8'h00);
    tick();
    check("t1_ext_data", O_ext_data, 8'hA5);
    check("t1_flag_before", O_ext_flags, 8'h00);
    check("t1_popped", O_tx_level, 0);
    tick();
    check("t1_flag_toggle", O_ext_flags, 8'h02);
    wr_seen = 1'b1;
    I_pulpino_flags[0] = ~I_pulpino_flags[0];
    tick();
    check("t1_idle", O_busy, 0);
    check("t1_data_held", O_ext_data, 8'hA5);

    // back-to-back pushes until the TX FIFO fills; one pop by LOAD frees one slot
    I_tx_valid = 1'b1; I_tx_data = 8'h01;
    for (int i = 0; i < 3 * DEPTH && O_tx_ready; i++) begin
      tx_q.push_back(I_tx_data);
      tick();
      I_tx_data = I_tx_data + 8'h01;
    end
    I_tx_valid = 1'b0;
    check("t2_accepted", tx_q.size(), DEPTH + 1);
    check("t2_ready_low", O_tx_ready, 0);
    check("t2_level_full", O_tx_level, DEPTH);
    for (int n = 0; n <= DEPTH; n++) begin
      wait_wr(ok);
      check("t2_wr_seen", ok, 1);
      check("t2_order", O_ext_data, tx_q.pop_front());
      I_pulpino_flags[0] = ~I_pulpino_flags[0];
    end
    tick();
    check("t2_idle", O_busy, 0);

    // RX fill until full, stalled request, then release by a pop
    I_rx_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      I_pulpino_data = 8'h3C + 8'(k);
      I_pulpino_flags[1] = ~I_pulpino_flags[1];
      tick();
      check("t3_ack", O_ext_flags[0], !rd_seen);
      rd_seen = ~rd_seen;
      rx_q.push_back(I_pulpino_data);
    end
    I_pulpino_data = 8'h3C + 8'(DEPTH);
    I_pulpino_flags[1] = ~I_pulpino_flags[1];
    repeat (3) tick();
    check("t3_stall_noack", O_ext_flags[0], rd_seen);
    check("t3_level_full", O_rx_level, DEPTH);
    check("t3_head", O_rx_data, rx_q[0]);
    I_rx_ready = 1'b1;
    tick();
    I_rx_ready = 1'b0;
    void'(rx_q.pop_front());
    check("t3_ack_after_pop_n", O_ext_flags[0], rd_seen);
    tick();
    check("t3_ack_after_pop", O_ext_flags[0], !rd_seen);
    rd_seen = ~rd_seen;
    rx_q.push_back(8'h3C + 8'(DEPTH));
    I_rx_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("t3_valid", O_rx_valid, 1);
      check("t3_order", O_rx_data, rx_q.pop_front());
      tick();
    end
    I_rx_ready = 1'b0;
    check("t3_empty", O_rx_valid, 0);
    check("t3_level0", O_rx_level, 0);

    // timeout: no ack for TMO cycles after entering WAIT_ACK
    I_tx_data = 8'h77; I_tx_valid = 1'b1;
    tick();
    I_tx_valid = 1'b0;
    wait_wr(ok);
    check("t4_wr_seen", ok, 1);
    check("t4_ext_data", O_ext_data, 8'h77);
    repeat (TMO - 1) tick();
    check("t4_not_yet", O_timeout, 0);
    tick();
    check("t4_timeout", O_timeout, 1);
    check("t4_still_wait", O_busy, 1);
    I_pulpino_flags[0] = ~I_pulpino_flags[0];
    tick();
    check("t4_idle", O_busy, 0);
    check("t4_sticky", O_timeout, 1);

    // flush in WAIT_ACK with 3 TX and 2 RX bytes queued and edges pending
    I_tx_data = 8'h81; I_tx_valid = 1'b1;
    tick();
    I_tx_valid = 1'b0;
    wait_wr(ok);
    check("t5_wr_seen", ok, 1);
    I_tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      I_tx_data = 8'h82 + 8'(k);
      tick();
    end
    I_tx_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      I_pulpino_data = 8'h91 + 8'(k);
      I_pulpino_flags[1] = ~I_pulpino_flags[1];
      tick();
      rd_seen = ~rd_seen;
    end
    repeat (TMO) tick();
    check("t5_pre_timeout", O_timeout, 1);
    check("t5_pre_tx_level", O_tx_level, 3);
    check("t5_pre_rx_level", O_rx_level, 2);
    saved_flags = O_ext_flags;
    I_clear = 1'b1;
    I_pulpino_data = 8'h99;
    I_pulpino_flags[0] = ~I_pulpino_flags[0];
    I_pulpino_flags[1] = ~I_pulpino_flags[1];
    tick();
    I_clear = 1'b0;
    check("t5_tx_level", O_tx_level, 0);
    check("t5_rx_level", O_rx_level, 0);
    check("t5_idle", O_busy, 0);
    check("t5_timeout_clr", O_timeout, 0);
    check("t5_flags_kept", O_ext_flags, saved_flags);
    repeat (3) tick();
    check("t5_edge_dropped", O_ext_flags, saved_flags);
    check("t5_rx_still_empty", O_rx_level, 0);
    check("t5_still_idle", O_busy, 0);

    // same-cycle: RX push at level 1 with host pop, plus TX ack
    I_pulpino_data = 8'h11;
    I_pulpino_flags[1] = ~I_pulpino_flags[1];
    tick();
    check("t6_ack1", O_ext_flags[0], !rd_seen);
    rd_seen = ~rd_seen;
    I_tx_data = 8'h66; I_tx_valid = 1'b1;
    tick();
    I_tx_valid = 1'b0;
    wait_wr(ok);
    check("t6_wr_seen", ok, 1);
    check("t6_ext_data", O_ext_data, 8'h66);
    check("t6_head", O_rx_data, 8'h11);
    I_pulpino_data = 8'h22;
    I_pulpino_flags[1] = ~I_pulpino_flags[1];
    I_pulpino_flags[0] = ~I_pulpino_flags[0];
    I_rx_ready = 1'b1;
    tick();
    I_rx_ready = 1'b0;
    check("t6_level_same", O_rx_level, 1);
    check("t6_new_head", O_rx_data, 8'h22);
    check("t6_rx_ack", O_ext_flags[0], !rd_seen);
    rd_seen = ~rd_seen;
    check("t6_tx_idle", O_busy, 0);
    I_rx_ready = 1'b1;
    tick();
    I_rx_ready = 1'b0;
    check("t6_drained", O_rx_level, 0);

    // random traffic scored against byte-order queues
    tx_q.delete(); rx_q.delete();
    must_ack = 1'b0; req_pend = 1'b0; ack_dly = -1; req_data = 8'h00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      filling = (cyc < 400);
      if (O_ext_flags[1] !== wr_seen) begin
        wr_seen = O_ext_flags[1];
        check("rnd_tx_pending", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) check("rnd_tx_data", O_ext_data, tx_q.pop_front());
        ack_dly = int'($urandom_range(0, 3));
      end
      acked = (O_ext_flags[0] !== rd_seen);
      if (must_ack) check("rnd_rx_ack_latency", acked, 1);
      if (acked) begin
        rd_seen = O_ext_flags[0];
        check("rnd_rx_req_pending", req_pend, 1);
        rx_q.push_back(req_data);
        req_pend = 1'b0;
      end
      check("rnd_rx_level", O_rx_level, rx_q.size());
      check("rnd_tx_ready", O_tx_ready, O_tx_level != LW'(DEPTH));
      I_tx_valid = filling && ($urandom_range(0, 1) == 1);
      I_tx_data  = 8'($urandom);
      if (I_tx_valid && O_tx_ready) tx_q.push_back(I_tx_data);
      I_rx_ready = ($urandom_range(0, 1) == 1);
      if (I_rx_ready && O_rx_valid && rx_q.size() != 0) begin
        check("rnd_rx_data", O_rx_data, rx_q.pop_front());
      end
      if (ack_dly == 0) begin
        I_pulpino_flags[0] = ~I_pulpino_flags[0];
        ack_dly = -1;
      end else if (ack_dly > 0) begin
        ack_dly--;
      end
      if (!req_pend && filling && $urandom_range(0, 2) == 0) begin
        req_data = 8'($urandom);
        I_pulpino_data = req_data;
        I_pulpino_flags[1] = ~I_pulpino_flags[1];
        req_pend = 1'b1;
      end
      must_ack = req_pend && (O_rx_level < LW'(DEPTH));
      tick();
    end
    I_tx_valid = 1'b0;
    I_rx_ready = 1'b0;
    check("end_tx_model_empty", tx_q.size(), 0);
    check("end_rx_model_empty", rx_q.size(), 0);
    check("end_tx_level", O_tx_level, 0);
    check("end_rx_level", O_rx_level, 0);
    check("end_busy", O_busy, 0);
    check("end_timeout", O_timeout, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
